imem_boot_loader: RTL

- Byte-stream program loader that sits directly upstream of the instruction memory inside riscv_top.
- Receives a framed program image over a valid/ready byte interface and assembles little-endian 32-bit words. Writes them into the IMEM write port and verifies an XOR checksum.
- Holds the core in reset until a valid image is fully loaded. This replaces backdoor memory preloading for bring-up and for the directed test flow.

---
 rtl/imem_boot_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: framed byte-stream program loader feeding the IMEM write port.
// Frame layout: 4-byte word count N, N little-endian data words, then a
// 4-byte XOR checksum of those words. The core is held in reset until a
// complete image with a matching checksum has been written.
module imem_boot_loader #(
  parameter int NB_WORD    = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int NB_ADDR    = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_rx_ready,
  output logic               o_imem_we,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_WORD-1:0] o_imem_wdata,
  output logic               o_core_reset,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [1:0]         o_err_code,
  output logic [NB_ADDR:0]   o_word_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t             state;
  logic [1:0]         byte_idx;
  logic [NB_WORD-1:0] word_sr;
  logic [NB_WORD-1:0] length;
  logic [NB_WORD-1:0] csum;

  logic               accept;
  logic               last_byte;
  logic [NB_WORD-1:0] assembled;
  logic [NB_WORD-1:0] count_after;

  // Byte handshake and little-endian assembly: each new byte enters at the
  // top, so after four bytes the first one has shifted down to bits 7:0.
  assign accept      = i_rx_valid && o_rx_ready;
  assign last_byte   = accept && (byte_idx == 2'd3);
  assign assembled   = {i_rx_data, word_sr[NB_WORD-1:8]};
  assign count_after = NB_WORD'(o_word_count) + NB_WORD'(1);

  // Loader FSM with all outputs registered; o_core_reset only falls on entry to DONE.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      byte_idx     <= 2'd0;
      word_sr      <= '0;
      length       <= '0;
      csum         <= '0;
      o_rx_ready   <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_core_reset <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_err_code   <= 2'd0;
      o_word_count <= '0;
    end else begin
      o_imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (i_start) begin
            state        <= HDR;
            byte_idx     <= 2'd0;
            word_sr      <= '0;
            length       <= '0;
            csum         <= '0;
            o_rx_ready   <= 1'b1;
            o_busy       <= 1'b1;
            o_core_reset <= 1'b1;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_err_code   <= 2'd0;
            o_word_count <= '0;
          end
        end
        HDR: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            word_sr  <= assembled;
          end
          if (last_byte) begin
            length <= assembled;
            if (assembled > NB_WORD'(IMEM_DEPTH)) begin
              state      <= ERR;
              o_error    <= 1'b1;
              o_err_code <= 2'd1;
              o_busy     <= 1'b0;
              o_rx_ready <= 1'b0;
            end else if (assembled == '0) begin
              state <= CHK;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            word_sr  <= assembled;
          end
          if (last_byte) begin
            o_imem_we    <= 1'b1;
            o_imem_addr  <= o_word_count[NB_ADDR-1:0];
            o_imem_wdata <= assembled;
            o_word_count <= o_word_count + 1'b1;
            csum         <= csum ^ assembled;
            if (count_after == length) begin
              state <= CHK;
            end
          end
        end
        CHK: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            word_sr  <= assembled;
          end
          if (last_byte) begin
            o_busy     <= 1'b0;
            o_rx_ready <= 1'b0;
            if (assembled == csum) begin
              state        <= DONE;
              o_done       <= 1'b1;
              o_core_reset <= 1'b0;
            end else begin
              state      <= ERR;
              o_error    <= 1'b1;
              o_err_code <= 2'd2;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
